icache: RTL and testbench
=========================

// Module: icache
// PURPOSE
//  Direct-mapped, read-only instruction cache; the responder end of the datapath's
//  instruction-fetch request (imemREN/imemaddr in, ihit/imemload out).
//  Hits return the instruction combinationally in the request cycle. Misses issue a
//  single-word read to the memory controller (iREN/iaddr/iwait/iload), then fill the frame.
//  Sits between the pipelined datapath and the memory controller, beside the dcache.
// PARAMETERS
//  SETS     16   number of frames; power of two, >=2; IDX_W = $clog2(SETS)
//  TAG_W    30-IDX_W   derived (localparam): address bits [31:IDX_W+2]
// PORTS
//  CLK        in   1   clock; all state updates on rising edge
//  nRST       in   1   asynchronous active-low reset
//  imemREN    in   1   datapath instruction read request
//  imemaddr   in   32  fetch byte address; bits [1:0] ignored
//  ihit       out  1   instruction valid this cycle
//  imemload   out  32  instruction word; 32'h0 whenever ihit=0
//  iREN       out  1   memory read request
//  iaddr      out  32  memory word address, {addr[31:2],2'b00}
//  iwait      in   1   memory busy; iload is valid in the first iREN cycle with iwait=0
//  iload      in   32  memory read data
// BEHAVIOUR
//  - Address split: tag=[31:IDX_W+2], idx=[IDX_W+1:2], byte offset=[1:0] (ignored).
//  - Reset (async, nRST=0): all valid bits cleared; state=IDLE; miss_addr=0.
//    Outputs: ihit=0, imemload=0, iREN=0, iaddr=0. Tag/data arrays need no reset.
//    Reset asserted mid-FETCH aborts the fetch immediately; no frame is written.
//  - FSM IDLE:
//    hit = imemREN & valid[idx] & tag match. When hit, ihit=1 and imemload=data[idx]
//    in the same cycle (0-cycle latency).
//    imemREN & !hit -> latch miss_addr=imemaddr and go to FETCH. ihit=0 in this cycle.
//    imemREN=0 -> ihit=0 and no memory traffic.
//  - FSM FETCH:
//    iREN=1; iaddr=word-aligned miss_addr, held stable for the whole fetch. ihit=0.
//    iwait=1 -> stay in FETCH.
//    iwait=0 -> write {valid=1, tag, iload} into frame idx(miss_addr); go to IDLE.
//    Fill cycle does not assert ihit. The re-lookup in the next IDLE cycle hits.
//  - Miss latency: 1 (detect) + W (iwait high cycles) + 1 (fill) before ihit, for an
//    unchanged imemaddr.
//  - imemaddr changes or imemREN drops during FETCH (branch redirect, stall):
//    the fetch completes and fills for miss_addr anyway; the next IDLE cycle looks up
//    the new address.
//  - Fill replaces any valid frame at that index (conflict eviction); no write-back.
//  - Same-index alternation (e.g. 0x00 and 0x40 at SETS=16) thrashes; this is the
//    correct behaviour.
//  - iREN is 0 in every cycle where state != FETCH.
// CONFIGURATION
//  ICACHE_PERF_EN defined: adds output ports hit_count[31:0] and miss_count[31:0].
//    Both reset to 0.
//    hit_count +1 per IDLE cycle with ihit=1.
//    miss_count +1 per IDLE->FETCH transition.
//    Both saturate at 32'hFFFF_FFFF.
//  ICACHE_PERF_EN undefined: the ports and counters do not exist; behaviour is otherwise
//    identical.
// STRUCTURE
//  - cpu_types_pkg gains:
//    typedef icachef_t {tag, idx, bytoff} address overlay;
//    typedef icache_frame_t {valid, tag, data};
//    enum icache_state_t {IDLE, FETCH}.
//  - Sub-module icache_frame_array: SETS x icache_frame_t storage with async read,
//    sync write, and async valid clear.
//  - FSM, hit compare and counters live in icache.
// TESTING
//  1 Reset then imemREN=1, imemaddr=0x0, iwait=0 for 1 cycle, iload=0x2001_0005:
//    iREN=1/iaddr=0x0 for 1 cycle; ihit=1 with imemload=0x2001_0005 on the 3rd cycle
//    after request.
//  2 Repeat fetch of 0x0: ihit=1 in the same cycle with iREN=0. Fetch of 0x2 also hits
//    (offset ignored).
//  3 Miss 0x40 with iwait high 3 cycles: iaddr=0x40 held 4 cycles.
//    Frame 0 now holds 0x40; a following fetch of 0x0 misses again.
//  4 Miss on 0x100, imemaddr switched to 0x104 during FETCH: fill goes to idx 0 only;
//    0x104 then misses and fetches iaddr=0x104.
//  5 nRST pulsed low during FETCH: iREN drops asynchronously; a later fetch of the
//    earlier filled 0x0 misses (valid cleared).
//  6 ICACHE_PERF_EN: scenarios 1-2 give miss_count=1 and hit_count=2.
//    Force hit_count=32'hFFFF_FFFE: two more hits -> 32'hFFFF_FFFF (saturates).

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg
//   Shared types for the instruction cache: the cache geometry, the fetch
//   address overlay, the frame layout and the controller state encoding.
//   The geometry is fixed here so that every file agrees on field widths.
//   The optional performance counters in icache are enabled by defining
//   ICACHE_PERF_EN.
package icache_pkg;

  // Number of frames (power of two, >= 2) and the derived field widths
  localparam int ICACHE_SETS = 16;
  localparam int IDX_W       = $clog2(ICACHE_SETS);
  localparam int TAG_W       = 30 - IDX_W;

  // Fetch byte address viewed as tag / index / byte offset
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [1:0]       bytoff;
  } icachef_t;

  // One cache frame
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } icache_frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  // Memory is word addressed on a byte bus; drop the byte offset
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_frame_array.sv
// icache_frame_array
//   ICACHE_SETS x icache_frame_t storage. Reads are asynchronous, writes
//   happen on the rising clock edge, and only the valid bits are reset
//   (asynchronously); tag and data contents are don't-care until filled.
// Ports
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset, clears all valid bits
//   rd_idx    in   lookup index
//   rd_frame  out  frame at rd_idx (combinational)
//   wr_en     in   write strobe
//   wr_idx    in   index to write
//   wr_frame  in   frame contents to write
module icache_frame_array
  import icache_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output icache_frame_t    rd_frame,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  icache_frame_t    wr_frame
);

  logic [ICACHE_SETS-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q  [ICACHE_SETS];
  logic [31:0]            data_q [ICACHE_SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_frame.valid;
    end
  end

  // Tag and data carry no reset; a frame is only trusted once valid is set
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_frame.tag;
      data_q[wr_idx] <= wr_frame.data;
    end
  end

  always_comb begin
    rd_frame       = '0;
    rd_frame.valid = valid_q[rd_idx];
    rd_frame.tag   = tag_q[rd_idx];
    rd_frame.data  = data_q[rd_idx];
  end

endmodule

// File: rtl/icache.sv
// icache
//   Direct-mapped, read-only instruction cache. Hits return the instruction
//   in the request cycle; a miss issues a single-word read to the memory
//   controller and fills the frame, after which the retried lookup hits.
//   Optional macro ICACHE_PERF_EN adds saturating hit/miss counters.
// Ports
//   CLK         in   clock
//   nRST        in   asynchronous active-low reset
//   imemREN     in   datapath instruction read request
//   imemaddr    in   fetch byte address (bits [1:0] ignored)
//   ihit        out  instruction valid this cycle
//   imemload    out  instruction word, zero when ihit=0
//   iREN        out  memory read request
//   iaddr       out  memory word address
//   iwait       in   memory busy
//   iload       in   memory read data
//   hit_count   out  (ICACHE_PERF_EN only) number of hit cycles
//   miss_count  out  (ICACHE_PERF_EN only) number of misses issued
module icache
  import icache_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  icache_state_t state_q;
  logic [31:0]   miss_addr_q;

  icachef_t      req_f;
  icachef_t      miss_f;
  icache_frame_t rd_frame;
  icache_frame_t wr_frame;
  logic          wr_en;
  logic          hit;
  logic          unused_bytoff;

  assign req_f         = icachef_t'(imemaddr);
  assign miss_f        = icachef_t'(miss_addr_q);
  assign unused_bytoff = ^{req_f.bytoff, miss_f.bytoff};

  icache_frame_array u_frames (
    .clk      (CLK),
    .rst_n    (nRST),
    .rd_idx   (req_f.idx),
    .rd_frame (rd_frame),
    .wr_en    (wr_en),
    .wr_idx   (miss_f.idx),
    .wr_frame (wr_frame)
  );

  // Hits are only reported from IDLE, so the fill cycle never raises ihit
  assign hit = (state_q == IDLE) && imemREN && rd_frame.valid &&
               (rd_frame.tag == req_f.tag);

  assign ihit     = hit;
  assign imemload = hit ? rd_frame.data : 32'h0;

  // The fetch always uses the latched miss address, even if the datapath
  // redirects or stalls while it is in flight
  assign iREN  = (state_q == FETCH);
  assign iaddr = (state_q == FETCH) ? word_align(miss_addr_q) : 32'h0;

  assign wr_en = (state_q == FETCH) && !iwait;

  always_comb begin
    wr_frame       = '0;
    wr_frame.valid = 1'b1;
    wr_frame.tag   = miss_f.tag;
    wr_frame.data  = iload;
  end

  // Miss controller: IDLE looks up, FETCH waits on memory then fills
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (imemREN && !hit) begin
            miss_addr_q <= imemaddr;
            state_q     <= FETCH;
          end
        end
        FETCH: begin
          if (!iwait) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Saturating event counters; they stick at all-ones rather than wrapping
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
    end else begin
      if (hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if ((state_q == IDLE) && imemREN && !hit &&
          (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache
//   Directed self-checking bench for icache. Inputs change on the falling
//   edge; outputs are sampled 2 time units later, well before the next
//   rising edge. Define ICACHE_PERF_EN to also exercise the counters.
module tb_icache;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int checks = 0;
  int errors = 0;

  icache dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one cycle of inputs on the falling edge, then let outputs settle
  task automatic applyStimulus(input logic ren, input logic [31:0] addr,
                               input logic wt, input logic [31:0] load);
    @(negedge CLK);
    imemREN  = ren;
    imemaddr = addr;
    iwait    = wt;
    iload    = load;
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic exp_hit,
                          input logic [31:0] exp_load, input logic exp_ren,
                          input logic [31:0] exp_addr);
    checkOutput({tag, ".ihit"},     {31'h0, ihit},  {31'h0, exp_hit});
    checkOutput({tag, ".imemload"}, imemload,       exp_load);
    checkOutput({tag, ".iREN"},     {31'h0, iREN},  {31'h0, exp_ren});
    checkOutput({tag, ".iaddr"},    iaddr,          exp_addr);
  endtask

  initial begin
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    iwait    = 1'b0;
    iload    = 32'h0;
    #2;
    checkAll("reset", 1'b0, 32'h0, 1'b0, 32'h0);
`ifdef ICACHE_PERF_EN
    checkOutput("reset.hit_count",  hit_count,  32'h0);
    checkOutput("reset.miss_count", miss_count, 32'h0);
`endif
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;

    // Scenario 1: cold miss on 0x0, memory answers at once
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h2001_0005);
    checkAll("s1.detect", 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h2001_0005);
    checkAll("s1.fetch", 1'b0, 32'h0, 1'b1, 32'h0);
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0);
    checkAll("s1.hit", 1'b1, 32'h2001_0005, 1'b0, 32'h0);

    // Scenario 2: repeat hit, byte offset ignored
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0);
    checkAll("s2.rehit", 1'b1, 32'h2001_0005, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h2, 1'b0, 32'h0);
    checkAll("s2.offset", 1'b1, 32'h2001_0005, 1'b0, 32'h0);
`ifdef ICACHE_PERF_EN
    checkOutput("s6.hit_count",  hit_count,  32'd2);
    checkOutput("s6.miss_count", miss_count, 32'd1);
    @(negedge CLK);
    force dut.hit_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.hit_cnt_q;
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0);
    checkOutput("s6.sat_first", hit_count, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0);
    checkOutput("s6.sat_hold", hit_count, 32'hFFFF_FFFF);
`endif

    // Scenario 3: conflict miss on 0x40 with three wait cycles
    applyStimulus(1'b1, 32'h40, 1'b1, 32'h0);
    checkAll("s3.detect", 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h40, 1'b1, 32'h0);
      checkAll($sformatf("s3.wait%0d", i), 1'b0, 32'h0, 1'b1, 32'h40);
    end
    applyStimulus(1'b1, 32'h40, 1'b0, 32'hDEAD_0040);
    checkAll("s3.fill", 1'b0, 32'h0, 1'b1, 32'h40);
    applyStimulus(1'b1, 32'h40, 1'b0, 32'h0);
    checkAll("s3.hit", 1'b1, 32'hDEAD_0040, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h2001_0005);
    checkAll("s3.evicted", 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h2001_0005);
    checkAll("s3.refetch", 1'b0, 32'h0, 1'b1, 32'h0);
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0);
    checkAll("s3.rehit", 1'b1, 32'h2001_0005, 1'b0, 32'h0);

    // Scenario 4: redirect during fetch, fill still lands on idx 0
    applyStimulus(1'b1, 32'h100, 1'b0, 32'h0);
    checkAll("s4.detect", 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h104, 1'b0, 32'h1111_0100);
    checkAll("s4.fetch", 1'b0, 32'h0, 1'b1, 32'h100);
    applyStimulus(1'b1, 32'h104, 1'b0, 32'h0);
    checkAll("s4.newmiss", 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h104, 1'b0, 32'h2222_0104);
    checkAll("s4.fetch104", 1'b0, 32'h0, 1'b1, 32'h104);
    applyStimulus(1'b1, 32'h104, 1'b0, 32'h0);
    checkAll("s4.hit104", 1'b1, 32'h2222_0104, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h100, 1'b0, 32'h0);
    checkAll("s4.hit100", 1'b1, 32'h1111_0100, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h2001_0005);
    checkAll("s4.miss0", 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h2001_0005);
    checkAll("s4.fetch0", 1'b0, 32'h0, 1'b1, 32'h0);
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0);
    checkAll("s4.hit0", 1'b1, 32'h2001_0005, 1'b0, 32'h0);

    // No request: no hit, no data, no memory traffic
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    checkAll("idle.a", 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    checkAll("idle.b", 1'b0, 32'h0, 1'b0, 32'h0);

    // Scenario 5: reset in the middle of a fetch
    applyStimulus(1'b1, 32'h200, 1'b1, 32'h0);
    checkAll("s5.detect", 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h200, 1'b1, 32'h0);
    checkAll("s5.fetch", 1'b0, 32'h0, 1'b1, 32'h200);
    nRST = 1'b0;
    #1;
    checkAll("s5.abort", 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge CLK);
    imemREN = 1'b0;
    nRST    = 1'b1;
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h2001_0005);
    checkAll("s5.cleared", 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h2001_0005);
    checkAll("s5.refetch", 1'b0, 32'h0, 1'b1, 32'h0);
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0);
    checkAll("s5.rehit", 1'b1, 32'h2001_0005, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
